// File: rtl/mesh_test_sequencer_if.sv
// Bundle of host-facing control/status and mesh-facing signals for the
// mesh test sequencer. The sequencer is the slave; the host plus mesh
// environment is the master.
interface mesh_test_sequencer_if #(
  parameter int X = 2,
  parameter int Y = 2
);
  localparam int N = X * Y;

  logic            go;
  logic [N-1:0]    send_mask;
  logic            start;
  logic [N-1:0]    enable_send;
  logic            mesh_done;
  logic [32*N-1:0] receive_count;
  logic            busy;
  logic            result_valid;
  logic            pass;
  logic            timed_out;
  logic [31:0]     total_received;
  logic [31:0]     run_cycles;

  modport master (
    output go, send_mask, mesh_done, receive_count,
    input  start, enable_send, busy, result_valid, pass, timed_out,
           total_received, run_cycles
  );

  modport slave (
    input  go, send_mask, mesh_done, receive_count,
    output start, enable_send, busy, result_valid, pass, timed_out,
           total_received, run_cycles
  );
endinterface

// File: rtl/mesh_test_sequencer.sv
// Mesh test sequencer: launches a traffic run on a PE mesh, waits for
// completion or timeout, lets the mesh settle, sums the per-PE receive
// counters one slice per cycle and reports pass/fail against the number
// of packets the enabled PEs were asked to send.
// Every output is a flop whose next value is chosen from the next state,
// so an output is valid in the same cycle the state it belongs to is.
module mesh_test_sequencer #(
  parameter int X            = 2,
  parameter int Y            = 2,
  parameter int NUM_PACKETS  = 100,
  parameter int TIMEOUT      = 100000,
  parameter int DRAIN_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,
  mesh_test_sequencer_if.slave bus
);

  localparam int N = X * Y;
  localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int TIMEOUT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    SUM,
    REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [31:0]   expected_q, expected_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          start_q, start_d;
  logic [N-1:0]  enable_send_q, enable_send_d;
  logic          busy_q, busy_d;
  logic          result_valid_q, result_valid_d;
  logic          pass_q, pass_d;
  logic          timed_out_q, timed_out_d;
  logic [31:0]   total_q, total_d;
  logic [31:0]   run_cycles_q, run_cycles_d;

  logic [31:0]   ones;
  logic [31:0]   slice;

  // Number of PEs enabled by the incoming mask, used to form the expected total
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + {31'd0, bus.send_mask[i]};
    end
  end

  // Receive counter slice selected by the SUM step counter
  always_comb begin
    slice = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == 32'(i)) begin
        slice = bus.receive_count[32*i +: 32];
      end
    end
  end

  // Next-state and next-output logic for the whole run sequence
  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    expected_d     = expected_q;
    cnt_d          = cnt_q;
    start_d        = 1'b0;
    enable_send_d  = '0;
    busy_d         = 1'b1;
    result_valid_d = result_valid_q;
    pass_d         = pass_q;
    timed_out_d    = timed_out_q;
    total_d        = total_q;
    run_cycles_d   = run_cycles_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.go) begin
          mask_d         = bus.send_mask;
          expected_d     = ones * 32'(NUM_PACKETS);
          result_valid_d = 1'b0;
          pass_d         = 1'b0;
          timed_out_d    = 1'b0;
          total_d        = '0;
          run_cycles_d   = '0;
          cnt_d          = '0;
          busy_d         = 1'b1;
          enable_send_d  = bus.send_mask;
          state_d        = ARM;
        end
      end

      ARM: begin
        start_d       = 1'b1;
        enable_send_d = mask_q;
        state_d       = RUN;
      end

      RUN: begin
        run_cycles_d = run_cycles_q + 32'd1;
        cnt_d        = '0;
        if (bus.mesh_done) begin
          state_d = DRAIN;
        end else if (run_cycles_q == 32'(TIMEOUT_LAST)) begin
          timed_out_d = 1'b1;
          state_d     = DRAIN;
        end else begin
          start_d       = 1'b1;
          enable_send_d = mask_q;
        end
      end

      DRAIN: begin
        if (cnt_q == 32'(DRAIN_LAST)) begin
          cnt_d   = '0;
          state_d = SUM;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      SUM: begin
        total_d = total_q + slice;
        if (cnt_q == 32'(N - 1)) begin
          cnt_d   = '0;
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      REPORT: begin
        pass_d         = !timed_out_q && (total_q == expected_q);
        result_valid_d = 1'b1;
        busy_d         = 1'b0;
        state_d        = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      expected_q     <= '0;
      cnt_q          <= '0;
      start_q        <= 1'b0;
      enable_send_q  <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      timed_out_q    <= 1'b0;
      total_q        <= '0;
      run_cycles_q   <= '0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      expected_q     <= expected_d;
      cnt_q          <= cnt_d;
      start_q        <= start_d;
      enable_send_q  <= enable_send_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      pass_q         <= pass_d;
      timed_out_q    <= timed_out_d;
      total_q        <= total_d;
      run_cycles_q   <= run_cycles_d;
    end
  end

  assign bus.start          = start_q;
  assign bus.enable_send    = enable_send_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.pass           = pass_q;
  assign bus.timed_out      = timed_out_q;
  assign bus.total_received = total_q;
  assign bus.run_cycles     = run_cycles_q;

endmodule

// File: tb/tb_mesh_test_sequencer.sv
// Testbench for mesh_test_sequencer: directed runs with a timeline model
// of when each phase of a run happens and what the outputs must show.
module tb_mesh_test_sequencer;

  localparam int X  = 2;
  localparam int Y  = 2;
  localparam int N  = X * Y;
  localparam int NP = 100;
  localparam int TO = 1000;
  localparam int DC = 4;
  localparam int NEVER = 100000;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   checking;

  mesh_test_sequencer_if #(.X(X), .Y(Y)) bus ();

  mesh_test_sequencer #(
    .X(X), .Y(Y), .NUM_PACKETS(NP), .TIMEOUT(TO), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Model of the current run: when go was taken and how the run unfolds
  bit           mHasRun;
  int           mGo;
  int           mRunLen;
  bit           mTimed;
  bit           mExpectPass;
  logic [N-1:0] mMask;
  logic [127:0] mCounts;

  // Expected outputs for the cycle being checked
  logic         eStart;
  logic [N-1:0] eEn;
  logic         eBusy;
  logic         eRv;
  logic         ePass;
  logic         eTo;
  logic [31:0]  eTotal;
  logic [31:0]  eRc;

  // Samples taken mid-run for literal checks
  logic [N-1:0] enArm;
  logic [N-1:0] enRun;
  logic         startArm;
  logic         startRun;
  logic [N-1:0] enLateRun;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Timeline of a run measured from the go edge: ARM, RUN, DRAIN, SUM, REPORT, IDLE
  task automatic computeModel(input int c);
    int off;
    int r;
    int k;
    eStart = 1'b0; eEn = '0; eBusy = 1'b0; eRv = 1'b0;
    ePass = 1'b0; eTo = 1'b0; eTotal = '0; eRc = '0;
    if (mHasRun) begin
      off = c - mGo;
      r = mRunLen;
      eBusy  = (off <= r + DC + N + 1);
      eStart = (off >= 1) && (off <= r);
      eEn    = (off <= r) ? mMask : '0;
      if (off == 0) eRc = 0;
      else if (off <= r) eRc = 32'(off - 1);
      else eRc = 32'(r);
      eTo = mTimed && (off > r);
      k = off - (r + DC + 1);
      if (k > N) k = N;
      for (int i = 0; i < N; i++) begin
        if (i < k) eTotal = eTotal + mCounts[32*i +: 32];
      end
      eRv   = (off >= r + DC + N + 2);
      ePass = eRv && mExpectPass;
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (checking) begin
      computeModel(cyc);
      checkOutput("start", {31'd0, bus.start}, {31'd0, eStart});
      checkOutput("enable_send", {28'd0, bus.enable_send}, {28'd0, eEn});
      checkOutput("busy", {31'd0, bus.busy}, {31'd0, eBusy});
      checkOutput("result_valid", {31'd0, bus.result_valid}, {31'd0, eRv});
      checkOutput("pass", {31'd0, bus.pass}, {31'd0, ePass});
      checkOutput("timed_out", {31'd0, bus.timed_out}, {31'd0, eTo});
      checkOutput("total_received", bus.total_received, eTotal);
      checkOutput("run_cycles", bus.run_cycles, eRc);
    end
  end

  // One launch: go with mask/counts, mesh_done from RUN index doneIdx,
  // optional go pulse at RUN index goIdx, optional reset at RUN index rstIdx
  task automatic applyStimulus(input logic [N-1:0] mask, input logic [127:0] counts,
                               input int doneIdx, input int goIdx, input int rstIdx);
    int r;
    logic [31:0] sum;
    logic [31:0] want;
    bus.send_mask     = mask;
    bus.receive_count = counts;
    bus.go            = 1'b1;
    step();
    bus.go = 1'b0;
    sum = counts[31:0] + counts[63:32] + counts[95:64] + counts[127:96];
    want = 32'($countones(mask) * NP);
    if (doneIdx < TO) begin
      r = doneIdx + 1;
      mTimed = 1'b0;
    end else begin
      r = TO;
      mTimed = 1'b1;
    end
    mGo = cyc;
    mRunLen = r;
    mMask = mask;
    mCounts = counts;
    mExpectPass = !mTimed && (sum == want);
    mHasRun = 1'b1;
    for (int off = 0; off <= r + DC + N + 3; off++) begin
      if (off == 0) begin enArm = bus.enable_send; startArm = bus.start; end
      if (off == 1) begin enRun = bus.enable_send; startRun = bus.start; end
      if (off == r) enLateRun = bus.enable_send;
      bus.mesh_done = (off >= doneIdx + 1) && (off <= r);
      if (goIdx >= 0 && off == goIdx + 1) begin
        bus.go = 1'b1;
        bus.send_mask = ~mask;
      end else begin
        bus.go = 1'b0;
      end
      if (rstIdx >= 0 && off == rstIdx + 1) begin
        rst = 1'b1;
        bus.go = 1'b1;
        step();
        mHasRun = 1'b0;
        rst = 1'b0;
        bus.go = 1'b0;
        bus.mesh_done = 1'b0;
        break;
      end
      step();
    end
    bus.go = 1'b0;
    bus.mesh_done = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    checking = 1'b0;
    mHasRun = 1'b0;
    mGo = 0; mRunLen = 0; mTimed = 1'b0; mExpectPass = 1'b0;
    mMask = '0; mCounts = '0;
    rst = 1'b1;
    bus.go = 1'b0;
    bus.send_mask = '0;
    bus.mesh_done = 1'b0;
    bus.receive_count = '0;
    step();
    step();
    rst = 1'b0;
    checking = 1'b1;
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    checkOutput("reset_start", {31'd0, bus.start}, 32'd0);
    step();

    $display("[TB] full mask, done at RUN cycle 50");
    applyStimulus(4'b1111, {32'd100, 32'd100, 32'd100, 32'd100}, 50, -1, -1);
    checkOutput("t1_run_cycles", bus.run_cycles, 32'd51);
    checkOutput("t1_total", bus.total_received, 32'd400);
    checkOutput("t1_pass", {31'd0, bus.pass}, 32'd1);
    checkOutput("t1_timed_out", {31'd0, bus.timed_out}, 32'd0);
    checkOutput("t1_result_valid", {31'd0, bus.result_valid}, 32'd1);
    checkOutput("t1_start_arm", {31'd0, startArm}, 32'd0);
    checkOutput("t1_start_run", {31'd0, startRun}, 32'd1);

    $display("[TB] partial mask 0101");
    applyStimulus(4'b0101, {32'd0, 32'd0, 32'd50, 32'd150}, 20, -1, -1);
    checkOutput("t2_total", bus.total_received, 32'd200);
    checkOutput("t2_pass", {31'd0, bus.pass}, 32'd1);
    checkOutput("t2_en_arm", {28'd0, enArm}, 32'd5);
    checkOutput("t2_en_run", {28'd0, enRun}, 32'd5);

    $display("[TB] one packet short");
    applyStimulus(4'b1111, {32'd99, 32'd100, 32'd100, 32'd100}, 10, -1, -1);
    checkOutput("t3_total", bus.total_received, 32'd399);
    checkOutput("t3_pass", {31'd0, bus.pass}, 32'd0);
    checkOutput("t3_timed_out", {31'd0, bus.timed_out}, 32'd0);

    $display("[TB] timeout");
    applyStimulus(4'b1111, {32'd100, 32'd100, 32'd100, 32'd100}, NEVER, -1, -1);
    checkOutput("t4_run_cycles", bus.run_cycles, 32'd1000);
    checkOutput("t4_timed_out", {31'd0, bus.timed_out}, 32'd1);
    checkOutput("t4_pass", {31'd0, bus.pass}, 32'd0);

    $display("[TB] done coincides with timeout, go ignored in RUN");
    applyStimulus(4'b1111, {32'd100, 32'd100, 32'd100, 32'd100}, 999, 500, -1);
    checkOutput("t5_timed_out", {31'd0, bus.timed_out}, 32'd0);
    checkOutput("t5_run_cycles", bus.run_cycles, 32'd1000);
    checkOutput("t5_pass", {31'd0, bus.pass}, 32'd1);
    checkOutput("t5_en_late_run", {28'd0, enLateRun}, 32'd15);

    $display("[TB] reset mid-RUN then normal run");
    applyStimulus(4'b1111, {32'd100, 32'd100, 32'd100, 32'd100}, NEVER, -1, 20);
    checkOutput("t6_start", {31'd0, bus.start}, 32'd0);
    checkOutput("t6_enable_send", {28'd0, bus.enable_send}, 32'd0);
    checkOutput("t6_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("t6_result_valid", {31'd0, bus.result_valid}, 32'd0);
    step();
    step();
    applyStimulus(4'b0011, {32'd0, 32'd0, 32'd100, 32'd100}, 5, -1, -1);
    checkOutput("t7_run_cycles", bus.run_cycles, 32'd6);
    checkOutput("t7_total", bus.total_received, 32'd200);
    checkOutput("t7_pass", {31'd0, bus.pass}, 32'd1);

    step();
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
